// File: rtl/gcd_arbiter.sv
// Round-robin arbiter sharing one gcd engine between NREQ requesters,
// with a watchdog that turns a hung engine into an error response.
//
// state | meaning
// IDLE  | waiting for any req, next grant searched from ptr+1
// ISSUE | operands captured, start pulse being launched
// WAIT  | engine running, watchdog counting
// RESP  | response held on rsp_* until the owner acks
module gcd_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_result,
    output logic                  rsp_err,
    input  logic [NREQ-1:0]       rsp_ack,
    output logic [WIDTH-1:0]      eng_a,
    output logic [WIDTH-1:0]      eng_b,
    output logic                  eng_start,
    input  logic [WIDTH-1:0]      eng_result,
    input  logic                  eng_done,
    output logic                  busy
);
    localparam int IDX_W = $clog2(NREQ);
    localparam int SUM_W = IDX_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t           state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] owner;
    logic [WD_W-1:0]  wd_cnt;
    logic [IDX_W-1:0] win;
    logic [IDX_W-1:0] cand;
    logic [SUM_W-1:0] cand_sum;
    logic             found;

    // Scan ptr+1, ptr+2, ... modulo NREQ; the first set req bit wins.
    always_comb begin
        win      = '0;
        found    = 1'b0;
        cand     = '0;
        cand_sum = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand_sum = SUM_W'(ptr) + SUM_W'(k);
            if (cand_sum >= SUM_W'(NREQ))
                cand_sum = cand_sum - SUM_W'(NREQ);
            cand = cand_sum[IDX_W-1:0];
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            ptr        <= IDX_W'(NREQ - 1);
            owner      <= '0;
            wd_cnt     <= '0;
            gnt        <= '0;
            rsp_valid  <= '0;
            rsp_result <= '0;
            rsp_err    <= 1'b0;
            eng_a      <= '0;
            eng_b      <= '0;
            eng_start  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            gnt       <= '0;
            eng_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        eng_a <= a_in[int'(win)*WIDTH +: WIDTH];
                        eng_b <= b_in[int'(win)*WIDTH +: WIDTH];
                        gnt   <= NREQ'(1) << win;
                        owner <= win;
                        busy  <= 1'b1;
                        state <= ISSUE;
                    end
                end
                ISSUE: begin
                    eng_start <= 1'b1;
                    wd_cnt    <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    // A completion landing on the timeout cycle still wins.
                    if (eng_done) begin
                        rsp_result <= eng_result;
                        rsp_err    <= 1'b0;
                        rsp_valid  <= NREQ'(1) << owner;
                        state      <= RESP;
                    end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                        rsp_result <= '0;
                        rsp_err    <= 1'b1;
                        rsp_valid  <= NREQ'(1) << owner;
                        state      <= RESP;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ack[owner]) begin
                        rsp_valid <= '0;
                        rsp_err   <= 1'b0;
                        ptr       <= owner;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter: the bench plays both requesters and engine,
// with hand-computed gcd results and grant orders.
module tb_gcd_arbiter;
    logic         clk = 1'b0;
    logic         reset_n;
    logic [3:0]   req;
    logic [127:0] a_in;
    logic [127:0] b_in;
    logic [3:0]   gnt;
    logic [3:0]   rsp_valid;
    logic [31:0]  rsp_result;
    logic         rsp_err;
    logic [3:0]   rsp_ack;
    logic [31:0]  eng_a;
    logic [31:0]  eng_b;
    logic         eng_start;
    logic [31:0]  eng_result;
    logic         eng_done;
    logic         busy;

    int total  = 0;
    int passed = 0;

    gcd_arbiter #(.NREQ(4), .WIDTH(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .a_in(a_in), .b_in(b_in),
        .gnt(gnt), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
        .rsp_err(rsp_err), .rsp_ack(rsp_ack), .eng_a(eng_a), .eng_b(eng_b),
        .eng_start(eng_start), .eng_result(eng_result), .eng_done(eng_done),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_gnt"}, 32'(gnt), 0);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
        check({tag, "_rsp_result"}, rsp_result, 0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 0);
        check({tag, "_eng_a"}, eng_a, 0);
        check({tag, "_eng_b"}, eng_b, 0);
        check({tag, "_eng_start"}, 32'(eng_start), 0);
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    task automatic wait_gnt(input int owner, input logic [31:0] ea, input logic [31:0] eb,
                            input logic [3:0] keep);
        int n = 0;
        while (gnt == 4'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("gnt", 32'(gnt), 32'(1) << owner);
        check("eng_a", eng_a, ea);
        check("eng_b", eng_b, eb);
        check("start_with_gnt", 32'(eng_start), 0);
        req = req & keep;
    endtask

    // Engine asserts done on the lat-th cycle after eng_start is seen.
    task automatic run_engine(input int lat, input logic [31:0] res);
        @(negedge clk);
        check("eng_start", 32'(eng_start), 1);
        check("gnt_pulse", 32'(gnt), 0);
        @(negedge clk);
        check("eng_start_pulse", 32'(eng_start), 0);
        repeat (lat - 2) @(negedge clk);
        eng_done   = 1'b1;
        eng_result = res;
        @(negedge clk);
        eng_done   = 1'b0;
        eng_result = 32'hdead_beef;
    endtask

    task automatic check_rsp(input int owner, input logic [31:0] res, input logic err);
        check("rsp_valid", 32'(rsp_valid), 32'(1) << owner);
        check("rsp_result", rsp_result, res);
        check("rsp_err", 32'(rsp_err), 32'(err));
        check("busy_resp", 32'(busy), 1);
    endtask

    task automatic do_ack(input int owner);
        rsp_ack = 4'(32'(1) << owner);
        @(negedge clk);
        rsp_ack = 4'b0;
        check("rsp_valid_clr", 32'(rsp_valid), 0);
        check("rsp_err_clr", 32'(rsp_err), 0);
        check("busy_idle", 32'(busy), 0);
    endtask

    task automatic serve(input int owner, input logic [31:0] ea, input logic [31:0] eb,
                         input int lat, input logic [31:0] res, input logic [3:0] keep);
        wait_gnt(owner, ea, eb, keep);
        run_engine(lat, res);
        check_rsp(owner, res, 1'b0);
        do_ack(owner);
    endtask

    initial begin
        logic [31:0] res_tab [4];
        int n;
        res_tab[0] = 32'd6; res_tab[1] = 32'd7; res_tab[2] = 32'd25; res_tab[3] = 32'd1;
        reset_n    = 1'b0;
        req        = 4'b0;
        rsp_ack    = 4'b0;
        eng_done   = 1'b0;
        eng_result = 32'b0;
        a_in = {32'd17, 32'd100, 32'd21, 32'd48};
        b_in = {32'd5,  32'd75,  32'd14, 32'd18};
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);

        // single requester
        req = 4'b0001;
        serve(0, 48, 18, 10, 6, 4'b1110);

        // fresh pointer (3): 1 wins over 3, then 3
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        req = 4'b1010;
        serve(1, 21, 14, 4, 7, 4'b1101);
        serve(3, 17, 5, 6, 1, 4'b0111);

        // continuous requests rotate 0,1,2,3,0,1,2,3
        req = 4'b1111;
        for (int k = 0; k < 8; k++)
            serve(k % 4, 32'(a_in[(k%4)*32 +: 32]), 32'(b_in[(k%4)*32 +: 32]), 3,
                  res_tab[k % 4], (k == 7) ? 4'b0000 : 4'b1111);

        // engine hangs: error response 16 cycles after eng_start
        req = 4'b0100;
        wait_gnt(2, 100, 75, 4'b0000);
        @(negedge clk);
        check("to_eng_start", 32'(eng_start), 1);
        n = 0;
        while (rsp_valid == 4'b0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("timeout_latency", 32'(n), 16);
        check_rsp(2, 0, 1'b1);
        do_ack(2);

        // done on the exact timeout cycle beats the watchdog
        req = 4'b0001;
        serve(0, 48, 18, 16, 6, 4'b0000);

        // reset during WAIT drops the transaction; late done is ignored
        req = 4'b0010;
        wait_gnt(1, 21, 14, 4'b0000);
        @(negedge clk);
        check("rst_eng_start", 32'(eng_start), 1);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(negedge clk);
        reset_n    = 1'b1;
        eng_done   = 1'b1;
        eng_result = 32'd99;
        @(negedge clk);
        eng_done = 1'b0;
        check("late_done_busy", 32'(busy), 0);
        check("late_done_valid", 32'(rsp_valid), 0);
        @(negedge clk);
        check("late_done_gnt", 32'(gnt), 0);
        req = 4'b0100;
        serve(2, 100, 75, 5, 25, 4'b0000);

        // delayed ack with non-owner acks and pending requests
        req = 4'b0001;
        wait_gnt(0, 48, 18, 4'b0000);
        req = 4'b1110;
        run_engine(4, 6);
        rsp_ack = 4'b1110;
        for (int c = 0; c < 5; c++) begin
            check("hold_valid", 32'(rsp_valid), 32'h1);
            check("hold_result", rsp_result, 6);
            check("hold_gnt", 32'(gnt), 0);
            @(negedge clk);
        end
        do_ack(0);
        serve(1, 21, 14, 3, 7, 4'b0000);
        req = 4'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/gcd_arbiter.md
Name: gcd_arbiter

Overview:
Shares one gcd engine between NREQ requesters using round-robin arbitration.
Each requester presents two operands with a level request. The arbiter grants one requester, captures its operands, pulses the engine start and waits for engine done. It then returns the result to the granted requester over a valid/ack handshake.
A watchdog flags an engine that never completes.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 32, operand/result width
TIMEOUT, 1024, max cycles waiting for eng_done before error response (>=2)

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
req  input  NREQ  per-requester request, level
a_in  input  NREQ*WIDTH  operand a, requester i in bits [i*WIDTH +: WIDTH]
b_in  input  NREQ*WIDTH  operand b, same packing
gnt  output  NREQ  one-hot, 1-cycle pulse: operands of that requester captured
rsp_valid  output  NREQ  one-hot, result valid for that requester
rsp_result  output  WIDTH  result, shared bus, meaningful only when rsp_valid!=0
rsp_err  output  1  qualifies rsp_valid: 1 = watchdog timeout, rsp_result=0
rsp_ack  input  NREQ  requester accepts response
eng_a  output  WIDTH  operand a to engine
eng_b  output  WIDTH  operand b to engine
eng_start  output  1  1-cycle start pulse to engine
eng_result  input  WIDTH  engine result, valid when eng_done=1
eng_done  input  1  engine completion pulse
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, reset_n low): state=IDLE, rr pointer=NREQ-1. All outputs 0: gnt, rsp_valid, rsp_result, rsp_err, eng_a, eng_b, eng_start, busy. Watchdog counter=0.
- All outputs are registered. Outputs change only on clk rising edge, except under async reset.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req!=0, the winner is the first set bit searching from ptr+1 upward, wrapping modulo NREQ.
  - Next edge: eng_a/eng_b <= winner's operands; gnt[winner]=1 for exactly that cycle; owner<=winner; go ISSUE.
  - If req==0, stay in IDLE.
- ISSUE: eng_start=1 for exactly one cycle; watchdog cleared; go WAIT.
- eng_a/eng_b hold their values from capture until the next capture.
- WAIT:
  - Watchdog increments each cycle.
  - On eng_done=1: rsp_result<=eng_result, rsp_err<=0, rsp_valid[owner]<=1, go RESP.
  - Else if watchdog reaches TIMEOUT-1: rsp_result<=0, rsp_err<=1, rsp_valid[owner]<=1, go RESP.
  - If eng_done and timeout occur in the same cycle, done wins.
- RESP:
  - rsp_valid, rsp_result and rsp_err are held until rsp_ack[owner]=1.
  - On that edge: rsp_valid<=0, rsp_err<=0, ptr<=owner, go IDLE.
  - rsp_ack bits of non-owners are ignored.
- Minimum turnaround, request to next grant: grant edge, then ISSUE, engine latency, RESP plus ack cycle, then IDLE. A new grant can occur on the edge after IDLE is re-entered.
- Requesters hold req and operands stable until gnt.
  - req still high after gnt is a new request, eligible on the next arbitration.
  - The owner's req is never granted while its response is pending (single outstanding).
- eng_done outside WAIT is ignored; no state change, no response.
- Operands pass through unmodified; zero operands are legal and handled by the engine.
- Reset mid-operation: in-flight request is dropped, no response. Requesters reissue.
- Fairness: under continuous requests from all requesters, each is granted once per NREQ grants.

Test Plan:
- Single request: req=4'b0001, a=48, b=18, engine model done after 10 cycles with 6 -> gnt[0] pulse, eng_start 1 cycle later, rsp_valid[0]=1 with rsp_result=6, rsp_err=0; ack -> busy=0.
- Simultaneous req=4'b1010 after reset (ptr=3) -> req1 granted first, then req3. Results 21/14->7 and 17/5->1 are routed to the matching rsp_valid bit.
- Continuous req=4'b1111 for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
- Engine never asserts done, TIMEOUT=16 -> rsp_valid[owner] 16 cycles after eng_start, rsp_err=1, rsp_result=0; next request proceeds normally.
- reset_n low during WAIT, then high -> all outputs 0, state IDLE. A late eng_done is ignored, and the following request completes correctly.
- Ack delayed 5 cycles, rsp_ack from a non-owner asserted meanwhile -> response held stable for all 5 cycles, non-owner ack has no effect, no new gnt before owner ack.
